// File: rtl/irq_hub.sv
// irq_hub: masked, prioritised interrupt receiver with CPU req/ack/done handshake (optional IRQ_SYNC_EN input synchronizer)
module irq_hub #(
    parameter int N = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] dev_irq,
    input  logic [1:0]   addr,
    input  logic         WE,
    input  logic [31:0]  Din,
    output logic [31:0]  Dout,
    output logic         int_req,
    input  logic         int_ack,
    input  logic         int_done
);
    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
    state_t       state;
    logic [N-1:0] mask, pending, irq_prev, irq_in, active, wclr, ackclr;
    logic         ge, em, ge_off, ack_ok, unused_din;
    logic [4:0]   cause_id, winner;
`ifdef IRQ_SYNC_EN
    logic [N-1:0] sync1, sync2;
    // two-flop synchronizer for device lines from other clock domains
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= dev_irq;
            sync2 <= sync1;
        end
    end
    assign irq_in = sync2;
`else
    assign irq_in = dev_irq;
`endif
    assign active     = pending & mask;
    assign ge_off     = WE && addr == 2'd3 && !Din[0];
    assign ack_ok     = state == REQ && int_ack && !ge_off;
    assign wclr       = (WE && addr == 2'd1) ? Din[N-1:0] : '0;
    assign ackclr     = (em && ack_ok) ? N'(1) << cause_id : '0;
    assign int_req    = state == REQ;
    assign unused_din = &{1'b0, Din[31:N]};
    // lowest set index of active wins
    always_comb begin
        winner = '0;
        for (int i = N - 1; i >= 0; i--) winner = active[i] ? 5'(i) : winner;
    end
    // bus read mux, unused bits read 0
    always_comb begin
        Dout = addr == 2'd0 ? 32'(mask) :
               addr == 2'd1 ? 32'(pending) :
               addr == 2'd2 ? {state != IDLE, 26'b0, cause_id} :
                              {30'b0, em, ge};
    end
    // registers, pending capture and edge history; a new edge beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (!reset) begin
            mask     <= '0;
            pending  <= '0;
            irq_prev <= '0;
            ge       <= 1'b0;
            em       <= 1'b0;
        end else begin
            if (WE && addr == 2'd0) mask <= Din[N-1:0];
            if (WE && addr == 2'd3) begin
                ge <= Din[0];
                em <= Din[1];
            end
            pending  <= em ? (pending & ~wclr & ~ackclr) | (irq_in & ~irq_prev) : irq_in;
            irq_prev <= irq_in;
        end
    end
    // request handshake: disabling GE in REQ withdraws the request and overrides any ack
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            cause_id <= '0;
        end else begin
            case (state)
                IDLE: if (ge && |active) begin
                    state    <= REQ;
                    cause_id <= winner;
                end
                REQ: state <= ge_off ? IDLE : int_ack ? SERVICE : REQ;
                SERVICE: state <= int_done ? IDLE : SERVICE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
